// File: rtl/cla_pkg.sv
// Shared definitions for the byte-serial carry-lookahead adder.
package cla_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

endpackage

// File: rtl/cla_byte_serial_adder_if.sv
// Operand/result handshake bundle between a producer and the byte-serial adder.
interface cla_byte_serial_adder_if #(
  parameter int WORDS = 4
);

  localparam int W = cla_pkg::SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum_out;
  logic         Cout_out;
  logic         V_out;

  modport master (
    output in_valid, A_in, B_in, Cin, out_ready,
    input  in_ready, out_valid, Sum_out, Cout_out, V_out
  );

  modport slave (
    input  in_valid, A_in, B_in, Cin, out_ready,
    output in_ready, out_valid, Sum_out, Cout_out, V_out
  );

endinterface

// File: rtl/cla_byte_serial_adder_cla.sv
// 8-bit carry-lookahead adder slice: generate/propagate terms feed the carry chain.
module cla
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  output logic [SLICE_W-1:0] Sum,
  output logic               Cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  always_comb begin
    g = A & B;
    p = A ^ B;
    c = '0;
    c[0] = Cin;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    Sum  = p ^ c[SLICE_W-1:0];
    Cout = c[SLICE_W];
  end

endmodule

// File: rtl/cla_byte_serial_adder.sv
// Wide adder that pushes one byte per cycle through a single 8-bit CLA,
// rippling the carry through a register and presenting a buffered result.
module cla_byte_serial_adder
  import cla_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cla_byte_serial_adder_if.slave   bus
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic               v_q, v_d;

  logic               in_ready;
  logic               accept;
  logic               last_byte;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] cla_sum;
  logic               cla_cout;

  cla u_cla (
    .A    (a_slice),
    .B    (b_slice),
    .Cin  (carry_q),
    .Sum  (cla_sum),
    .Cout (cla_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      v_q         <= v_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
    accept    = bus.in_valid && in_ready;
    last_byte = (idx_q == LAST_IDX);
    a_slice   = a_q[SLICE_W*idx_q +: SLICE_W];
    b_slice   = b_q[SLICE_W*idx_q +: SLICE_W];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last_byte) state_d = HOLD;
      HOLD: begin
        if (accept) begin
          state_d = RUN;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new accept (including the one overlapping HOLD) reloads the operands;
  // otherwise each RUN cycle retires one byte and advances the carry.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    v_d         = v_q;
    if (accept) begin
      a_d     = bus.A_in;
      b_d     = bus.B_in;
      carry_d = bus.Cin;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[SLICE_W*idx_q +: SLICE_W] = cla_sum;
      carry_d = cla_cout;
      if (last_byte) begin
        v_d = (a_q[W-1] == b_q[W-1]) && (cla_sum[SLICE_W-1] != a_q[W-1]);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    out_valid_d = (state_d == HOLD);
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.Sum_out   = sum_q;
    bus.Cout_out  = carry_q;
    bus.V_out     = v_q;
  end

endmodule
